// File: rtl/pattern_scan_ctrl_if.sv
// Job/byte interface for pattern_scan_ctrl: host job launch, byte stream, status.
// Build with PATTERN_MASK_EN defined to add the cfg_mask don't-care input.
interface pattern_scan_ctrl_if #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 5,
   parameter int CNT_W   = 8
);
   logic               start;
   logic               abort;
   logic [MAX_LEN-1:0] cfg_pattern;
`ifdef PATTERN_MASK_EN
   logic [MAX_LEN-1:0] cfg_mask;
`endif
   logic [LEN_W-1:0]   cfg_len;
   logic [7:0]         cfg_nbytes;
   logic [7:0]         byte_in;
   logic               byte_valid;
   logic               byte_ready;
   logic               busy;
   logic               match_pulse;
   logic [CNT_W-1:0]   match_cnt;
   logic               done;
   logic [1:0]         dbg_state;

   modport master (
      output start, abort, cfg_pattern, cfg_len, cfg_nbytes, byte_in, byte_valid,
`ifdef PATTERN_MASK_EN
      output cfg_mask,
`endif
      input  byte_ready, busy, match_pulse, match_cnt, done, dbg_state
   );

   modport slave (
      input  start, abort, cfg_pattern, cfg_len, cfg_nbytes, byte_in, byte_valid,
`ifdef PATTERN_MASK_EN
      input  cfg_mask,
`endif
      output byte_ready, busy, match_pulse, match_cnt, done, dbg_state
   );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Programmable serial pattern-match job controller (MSB-first, overlapping match).
// Optional PATTERN_MASK_EN: latched cfg_mask marks don't-care pattern bits.
module pattern_scan_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 5,
   parameter int CNT_W   = 8
) (
   input logic                clk,
   input logic                reset,
   pattern_scan_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t             state, state_nxt;
   logic [MAX_LEN-1:0] pat_q, hist_q, hist_nxt, cmp_mask;
`ifdef PATTERN_MASK_EN
   logic [MAX_LEN-1:0] mask_q;
`endif
   logic [LEN_W-1:0]   len_q, seen_q, seen_nxt;
   logic [7:0]         nbytes_q, byte_cnt_q, sbuf_q;
   logic [2:0]         bit_idx_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               match_q;
   logic               len_ok, job_go, byte_go, shift_go, hit;

   // Byte handshake: a byte transfers on a rising edge where byte_valid and
   // byte_ready are both high; the source holds byte_in/byte_valid until then.
   always_comb begin
      len_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_L);
      job_go   = (state == S_IDLE) && bus.start && !bus.abort && len_ok;
      byte_go  = (state == S_WAIT) && bus.byte_valid && !bus.abort;
      shift_go = (state == S_SHIFT) && !bus.abort;
      hist_nxt = {hist_q[MAX_LEN-2:0], sbuf_q[bit_idx_q]};
      seen_nxt = (seen_q == MAX_LEN_L) ? seen_q : seen_q + LEN_W'(1);
      cmp_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
`ifdef PATTERN_MASK_EN
         cmp_mask[i] = (LEN_W'(i) < len_q) && mask_q[i];
`else
         cmp_mask[i] = (LEN_W'(i) < len_q);
`endif
      end
      hit = (seen_nxt >= len_q) && (((hist_nxt ^ pat_q) & cmp_mask) == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      bus.byte_ready  = 1'b0;
      bus.busy        = 1'b0;
      bus.done        = 1'b0;
      bus.match_pulse = match_q;
      bus.match_cnt   = cnt_q;
      bus.dbg_state   = state;
      case (state)
         S_IDLE: begin
            if (job_go) state_nxt = (bus.cfg_nbytes == 8'd0) ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            bus.byte_ready = 1'b1;
            bus.busy       = 1'b1;
            if (bus.abort)           state_nxt = S_IDLE;
            else if (bus.byte_valid) state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            bus.busy = 1'b1;
            if (bus.abort) state_nxt = S_IDLE;
            else if (bit_idx_q == 3'd0)
               state_nxt = (byte_cnt_q == nbytes_q) ? S_DONE : S_WAIT;
         end
         S_DONE: begin
            // An abort in the completion cycle cancels the done indication.
            bus.done  = !bus.abort;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat_q      <= '0;
`ifdef PATTERN_MASK_EN
         mask_q     <= '0;
`endif
         len_q      <= '0;
         nbytes_q   <= '0;
         hist_q     <= '0;
         seen_q     <= '0;
         sbuf_q     <= '0;
         bit_idx_q  <= '0;
         byte_cnt_q <= '0;
         cnt_q      <= '0;
         match_q    <= 1'b0;
      end else begin
         match_q <= shift_go && hit;
         if (job_go) begin
            pat_q      <= bus.cfg_pattern;
`ifdef PATTERN_MASK_EN
            mask_q     <= bus.cfg_mask;
`endif
            len_q      <= bus.cfg_len;
            nbytes_q   <= bus.cfg_nbytes;
            hist_q     <= '0;
            seen_q     <= '0;
            byte_cnt_q <= '0;
            cnt_q      <= '0;
         end
         if (byte_go) begin
            sbuf_q     <= bus.byte_in;
            bit_idx_q  <= 3'd7;
            byte_cnt_q <= byte_cnt_q + 8'd1;
         end
         // History carries across bytes and matches so overlapping and
         // byte-spanning occurrences are all seen.
         if (shift_go) begin
            hist_q    <= hist_nxt;
            seen_q    <= seen_nxt;
            bit_idx_q <= bit_idx_q - 3'd1;
            if (hit && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: directed vector table, hand sequences for abort/reset/
// illegal start, and random jobs checked against a bit-list matching model.
module tb_pattern_scan_ctrl;
   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 5;
   localparam int CNT_W   = 8;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   pattern_scan_ctrl_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

   pattern_scan_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [7:0]       pat;
      logic [LEN_W-1:0] len;
      logic [7:0]       nb;
      logic [7:0]       b[4];
      int               gap;
      int               exp_pulses;
      int               exp_cnt;
   } vec_t;

   int               tests = 0;
   int               fails = 0;
   logic [7:0]       job_bytes[256];
   logic [CNT_W-1:0] exp_q[$];
   vec_t             vecs[7];

   function automatic void check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Reference: flatten the bytes MSB-first into a bit list and count every
   // position whose trailing len bits equal the pattern (bit 0 = newest).
   function automatic int model_count(input logic [7:0] pat, input int len, input int nb);
      bit bits[$];
      int cnt = 0;
      for (int b = 0; b < nb; b++)
         for (int k = 7; k >= 0; k--) bits.push_back(job_bytes[b][k]);
      for (int i = 0; i < bits.size(); i++) begin
         if (i + 1 >= len) begin
            bit ok = 1'b1;
            for (int j = 0; j < len; j++)
               if (bits[i-j] != pat[j]) ok = 1'b0;
            if (ok) cnt++;
         end
      end
      return cnt;
   endfunction

   task automatic drive_idle();
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.cfg_pattern = '0;
      bus.cfg_len     = '0;
      bus.cfg_nbytes  = '0;
      bus.byte_in     = '0;
      bus.byte_valid  = 1'b0;
`ifdef PATTERN_MASK_EN
      bus.cfg_mask    = '1;
`endif
   endtask

   task automatic launch(input logic [7:0] pat, input logic [LEN_W-1:0] len, input logic [7:0] nb);
      @(negedge clk);
      bus.start       = 1'b1;
      bus.cfg_pattern = pat;
      bus.cfg_len     = len;
      bus.cfg_nbytes  = nb;
      @(negedge clk);
      bus.start       = 1'b0;
      bus.cfg_pattern = ~pat;
      bus.cfg_len     = '0;
      bus.cfg_nbytes  = 8'hFF;
   endtask

   // Runs one whole job; expected final count is taken from exp_q.
   task automatic run_job(input string tag, input logic [7:0] pat, input logic [LEN_W-1:0] len,
                          input logic [7:0] nb, input int gap, input int exp_pulses);
      int pulses = 0, busy_err = 0, done_cyc = -1, gap_left = 0, bi = 0, exp_done;
      bit will_acc = 1'b0;
      logic [CNT_W-1:0] exp_cnt;
      exp_done = (nb == 0) ? 0 : 9 * nb + gap * (nb - 1);
      launch(pat, len, nb);
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (will_acc) begin
            bi++;
            bus.byte_valid = 1'b0;
            bus.byte_in    = 8'h5A;
            gap_left       = gap;
            will_acc       = 1'b0;
         end
         if (bus.match_pulse) pulses++;
         if (bus.done) begin
            done_cyc = cyc;
            break;
         end
         if (!bus.busy) busy_err++;
         if (!bus.byte_valid && bi < nb && bus.byte_ready) begin
            if (gap_left > 0) gap_left--;
            else begin
               bus.byte_valid = 1'b1;
               bus.byte_in    = job_bytes[bi];
            end
         end
         will_acc = bus.byte_valid && bus.byte_ready;
      end
      bus.byte_valid = 1'b0;
      exp_cnt = exp_q.pop_front();
      check({tag, " done_cycle"}, done_cyc, exp_done);
      check({tag, " pulses"}, pulses, exp_pulses);
      check({tag, " match_cnt"}, bus.match_cnt, exp_cnt);
      check({tag, " busy_during_job_errors"}, busy_err, 0);
      check({tag, " busy_at_done"}, bus.busy, 0);
      @(negedge clk);
      check({tag, " done_one_cycle"}, bus.done, 0);
      check({tag, " match_cnt_held"}, bus.match_cnt, exp_cnt);
   endtask

   initial begin
      drive_idle();
      #12;
      check("reset outputs", {bus.byte_ready, bus.busy, bus.match_pulse, bus.done}, 0);
      check("reset match_cnt", bus.match_cnt, 0);
      #6 reset = 1'b1;

      // pattern, len, nbytes, bytes, gap, pulses, final count
      vecs[0] = '{pat: 8'h0A, len: 4, nb: 1, b: '{8'hAA, 8'h00, 8'h00, 8'h00}, gap: 0, exp_pulses: 3,   exp_cnt: 3};
      vecs[1] = '{pat: 8'h03, len: 2, nb: 1, b: '{8'hFF, 8'h00, 8'h00, 8'h00}, gap: 0, exp_pulses: 7,   exp_cnt: 7};
      vecs[2] = '{pat: 8'h09, len: 4, nb: 2, b: '{8'h01, 8'h20, 8'h00, 8'h00}, gap: 0, exp_pulses: 1,   exp_cnt: 1};
      vecs[3] = '{pat: 8'h09, len: 4, nb: 2, b: '{8'h01, 8'h20, 8'h00, 8'h00}, gap: 5, exp_pulses: 1,   exp_cnt: 1};
      vecs[4] = '{pat: 8'h0A, len: 4, nb: 0, b: '{8'hAA, 8'h00, 8'h00, 8'h00}, gap: 0, exp_pulses: 0,   exp_cnt: 0};
      vecs[5] = '{pat: 8'h01, len: 1, nb: 38, b: '{8'hFF, 8'hFF, 8'hFF, 8'hFF}, gap: 0, exp_pulses: 304, exp_cnt: 255};
      vecs[6] = '{pat: 8'hA5, len: 8, nb: 2, b: '{8'h0A, 8'h50, 8'h00, 8'h00}, gap: 1, exp_pulses: 1,   exp_cnt: 1};

      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < int'(vecs[v].nb); i++) job_bytes[i] = (i < 4) ? vecs[v].b[i] : vecs[v].b[3];
         exp_q.push_back(CNT_W'(vecs[v].exp_cnt));
         run_job($sformatf("vec%0d", v), vecs[v].pat, vecs[v].len, vecs[v].nb, vecs[v].gap, vecs[v].exp_pulses);
      end

      // Illegal lengths (0 and MAX_LEN+1) are ignored and keep the last count.
      job_bytes[0] = 8'hAA;
      exp_q.push_back(CNT_W'(3));
      run_job("pre_illegal", 8'h0A, 4, 1, 0, 3);
      launch(8'h0A, 0, 1);
      check("len0 ignored busy", bus.busy, 0);
      check("len0 ignored match_cnt", bus.match_cnt, 3);
      launch(8'h0A, 5'd9, 1);
      check("len9 ignored busy", bus.busy, 0);
      check("len9 ignored match_cnt", bus.match_cnt, 3);

      // Abort on the 3rd SHIFT cycle: one match (bit 2) already counted.
      launch(8'h02, 2, 1);
      bus.byte_valid = 1'b1;
      bus.byte_in    = 8'hAA;
      @(negedge clk);
      bus.byte_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort pre pulse", bus.match_pulse, 1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort busy", bus.busy, 0);
      check("abort pulse suppressed", bus.match_pulse, 0);
      check("abort match_cnt frozen", bus.match_cnt, 1);
      begin
         int seen_done = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.match_pulse) seen_done++;
         end
         check("abort no done/pulse", seen_done, 0);
      end
      check("abort cnt still frozen", bus.match_cnt, 1);
      launch(8'h02, 2, 1);
      check("restart clears match_cnt", bus.match_cnt, 0);
      check("restart in WAIT", {bus.busy, bus.byte_ready}, 2'b11);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort in WAIT", {bus.busy, bus.byte_ready, bus.done}, 0);

      // Start together with abort: abort wins.
      @(negedge clk);
      bus.start = 1'b1; bus.abort = 1'b1; bus.cfg_len = 4; bus.cfg_nbytes = 1;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      check("start+abort ignored", bus.busy, 0);

      // Asynchronous reset in the middle of SHIFT.
      launch(8'h01, 1, 1);
      bus.byte_valid = 1'b1;
      bus.byte_in    = 8'hFF;
      @(negedge clk);
      bus.byte_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre-reset busy", bus.busy, 1);
      #2 reset = 1'b0;
      #1;
      check("async reset outputs", {bus.byte_ready, bus.busy, bus.match_pulse, bus.done}, 0);
      check("async reset match_cnt", bus.match_cnt, 0);
      @(negedge clk);
      #2 reset = 1'b1;

      // Random jobs against the reference model.
      for (int r = 0; r < 20; r++) begin
         logic [7:0] pat;
         int len, nb, gap, raw;
         pat = 8'($urandom);
         len = $urandom_range(1, MAX_LEN);
         nb  = $urandom_range(1, 4);
         gap = $urandom_range(0, 3);
         for (int i = 0; i < nb; i++) job_bytes[i] = (r % 3 == 0) ? (pat & 8'h0F) | 8'($urandom) & 8'hF0 : 8'($urandom);
         raw = model_count(pat, len, nb);
         exp_q.push_back((raw > 255) ? CNT_W'(255) : CNT_W'(raw));
         run_job($sformatf("rnd%0d", r), pat, LEN_W'(len), 8'(nb), gap, raw);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
